// File: rtl/bsg_chip_reset_sequencer_pkg.sv
// Shared definitions for the chip-side reset sequencer and gateway-side status decode.
// Latency: n/a (types and helpers only).
// Backpressure: n/a.
package bsg_chip_reset_pkg;

    // Bring-up stage encoding, also driven out on the debug/status pins.
    typedef enum logic [2:0] {
        e_wait0    = 3'd0,
        e_lrst_on  = 3'd1,
        e_lrst_off = 3'd2,
        e_len      = 3'd3,
        e_crst_off = 3'd4,
        e_done     = 3'd5
    } bsg_chip_reset_state_e;

    // Successor of a timed stage; DONE holds, and unused encodings fall back to WAIT0.
    function automatic logic [2:0] bsg_chip_reset_next_stage(input logic [2:0] s);
        logic [2:0] n;
        case (s)
            e_wait0:    n = e_lrst_on;
            e_lrst_on:  n = e_lrst_off;
            e_lrst_off: n = e_len;
            e_len:      n = e_crst_off;
            e_crst_off: n = e_done;
            e_done:     n = e_done;
            default:    n = e_wait0;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/bsg_chip_reset_sequencer_if.sv
// Bring-up control/status bundle from the reset sequencer to link, routers and status pins.
// Latency: n/a (wires only).
// Backpressure: none; level signals, no handshake.
interface bsg_chip_reset_sequencer_if;
    logic       link_reset_o;
    logic       link_enable_o;
    logic       chip_reset_o;
    logic       node_en_o;
    logic [2:0] stage_o;
    logic       ready_o;

    modport master (
        output link_reset_o,
        output link_enable_o,
        output chip_reset_o,
        output node_en_o,
        output stage_o,
        output ready_o
    );

    modport slave (
        input link_reset_o,
        input link_enable_o,
        input chip_reset_o,
        input node_en_o,
        input stage_o,
        input ready_o
    );
endinterface

// File: rtl/bsg_chip_reset_sequencer_deglitch.sv
// Synchronizes the gateway reset pin and accepts it only after a run of synced-high cycles.
// Latency: 2 sync cycles + deglitch_cycles_p samples until accepted_o rises; falls 1 cycle after synced low.
// Backpressure: none; free-running level filter.
module bsg_reset_deglitch #(
    parameter int deglitch_cycles_p = 16
) (
    input  logic clk_i,
    input  logic reset_n_i,
    input  logic ext_reset_i,
    output logic accepted_o
);
    localparam int run_width_lp = $clog2(deglitch_cycles_p + 1);
    localparam logic [run_width_lp-1:0] run_last_lp = run_width_lp'(deglitch_cycles_p - 1);

    logic                    sync1_q, sync2_q;
    logic [run_width_lp-1:0] run_q, run_d;
    logic                    accepted_q, accepted_d;

    // Two-flop synchronizer for the asynchronous gateway pin.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= ext_reset_i;
            sync2_q <= sync1_q;
        end
    end

    // Count consecutive synced-high samples (saturating); any synced-low sample drops acceptance.
    always_comb begin
        run_d      = '0;
        accepted_d = 1'b0;
        if (sync2_q) begin
            run_d      = (run_q == run_last_lp) ? run_q : run_q + run_width_lp'(1);
            accepted_d = (run_q == run_last_lp);
        end
    end

    // Acceptance starts asserted so the sequencer holds until the pin is seen low.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            run_q      <= '0;
            accepted_q <= 1'b1;
        end else begin
            run_q      <= run_d;
            accepted_q <= accepted_d;
        end
    end

    assign accepted_o = accepted_q;
endmodule

// File: rtl/bsg_chip_reset_sequencer.sv
// Replays the staged bring-up (link reset pulse, link enable, chip reset release, node enable).
// Latency: stage_cycles_p cycles per stage; outputs registered, change first cycle of the next stage.
// Backpressure: none; an accepted external reset restarts the sequence from WAIT0 at any time.
module bsg_chip_reset_sequencer
    import bsg_chip_reset_pkg::*;
#(
    parameter int stage_cycles_p    = 5000,
    parameter int deglitch_cycles_p = 16
) (
    input  logic                          clk_i,
    input  logic                          reset_n_i,
    input  logic                          ext_reset_i,
    bsg_chip_reset_sequencer_if.master    bring_up_o
);
    localparam int max_cycles_lp = (stage_cycles_p > deglitch_cycles_p) ? stage_cycles_p
                                                                         : deglitch_cycles_p;
    localparam int cnt_width_lp  = $clog2(max_cycles_lp + 1);
    localparam logic [cnt_width_lp-1:0] cnt_last_lp = cnt_width_lp'(stage_cycles_p - 1);

    localparam logic [2:0] st_wait0_lp    = e_wait0;
    localparam logic [2:0] st_lrst_on_lp  = e_lrst_on;
    localparam logic [2:0] st_lrst_off_lp = e_lrst_off;
    localparam logic [2:0] st_len_lp      = e_len;
    localparam logic [2:0] st_crst_off_lp = e_crst_off;
    localparam logic [2:0] st_done_lp     = e_done;

    logic                    accepted;
    logic                    restart;
    logic [2:0]              state_q, state_d;
    logic [cnt_width_lp-1:0] cnt_q, cnt_d;
    logic                    link_reset_q, link_reset_d;
    logic                    link_enable_q, link_enable_d;
    logic                    chip_reset_q, chip_reset_d;
    logic                    node_en_q, node_en_d;
    logic                    ready_q, ready_d;

    bsg_reset_deglitch #(
        .deglitch_cycles_p (deglitch_cycles_p)
    ) deglitch (
        .clk_i       (clk_i),
        .reset_n_i   (reset_n_i),
        .ext_reset_i (ext_reset_i),
        .accepted_o  (accepted)
    );

    // Accepted ext reset or an unreachable encoding sends everything back to the reset picture.
    assign restart = accepted || (state_q > st_done_lp);

    // Stage sequencing: count out each timed stage, step outputs on the terminal-count cycle.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        link_reset_d  = link_reset_q;
        link_enable_d = link_enable_q;
        chip_reset_d  = chip_reset_q;
        node_en_d     = node_en_q;
        ready_d       = ready_q;
        if (restart) begin
            state_d       = st_wait0_lp;
            cnt_d         = '0;
            link_reset_d  = 1'b0;
            link_enable_d = 1'b0;
            chip_reset_d  = 1'b1;
            node_en_d     = 1'b0;
            ready_d       = 1'b0;
        end else if (state_q == st_done_lp) begin
            cnt_d = '0;
        end else if (cnt_q == cnt_last_lp) begin
            cnt_d   = '0;
            state_d = bsg_chip_reset_next_stage(state_q);
            case (state_q)
                st_wait0_lp:    link_reset_d  = 1'b1;
                st_lrst_on_lp:  link_reset_d  = 1'b0;
                st_lrst_off_lp: link_enable_d = 1'b1;
                st_len_lp:      chip_reset_d  = 1'b0;
                st_crst_off_lp: begin
                    node_en_d = 1'b1;
                    ready_d   = 1'b1;
                end
                default: ;
            endcase
        end else begin
            cnt_d = cnt_q + cnt_width_lp'(1);
        end
    end

    // State, counter and output registers; power-on reset holds the chip in reset.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q       <= st_wait0_lp;
            cnt_q         <= '0;
            link_reset_q  <= 1'b0;
            link_enable_q <= 1'b0;
            chip_reset_q  <= 1'b1;
            node_en_q     <= 1'b0;
            ready_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            link_reset_q  <= link_reset_d;
            link_enable_q <= link_enable_d;
            chip_reset_q  <= chip_reset_d;
            node_en_q     <= node_en_d;
            ready_q       <= ready_d;
        end
    end

    assign bring_up_o.link_reset_o  = link_reset_q;
    assign bring_up_o.link_enable_o = link_enable_q;
    assign bring_up_o.chip_reset_o  = chip_reset_q;
    assign bring_up_o.node_en_o     = node_en_q;
    assign bring_up_o.stage_o       = state_q;
    assign bring_up_o.ready_o       = ready_q;
endmodule

// File: tb/tb_bsg_chip_reset_sequencer.sv
// Self-checking bench for bsg_chip_reset_sequencer with stage_cycles_p=8, deglitch_cycles_p=4.
// Cycle index n means the state after the (n+1)-th rising edge following reset_n release.
module tb_bsg_chip_reset_sequencer;
    localparam int S = 8;
    localparam int D = 4;
    // {stage[2:0], ready, node_en, chip_reset, link_enable, link_reset}
    localparam logic [7:0] RST_VEC  = 8'b000_0_0_1_0_0;
    localparam logic [7:0] DONE_VEC = 8'b101_1_1_0_1_0;

    logic clk = 1'b0;
    logic reset_n;
    logic ext;

    bsg_chip_reset_sequencer_if bus ();

    bsg_chip_reset_sequencer #(
        .stage_cycles_p    (S),
        .deglitch_cycles_p (D)
    ) dut (
        .clk_i       (clk),
        .reset_n_i   (reset_n),
        .ext_reset_i (ext),
        .bring_up_o  (bus)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [7:0] obs_vec();
        return {bus.stage_o, bus.ready_o, bus.node_en_o, bus.chip_reset_o,
                bus.link_enable_o, bus.link_reset_o};
    endfunction

    // Expected outputs from elapsed un-reset cycles: stage index is simply elapsed / S.
    function automatic logic [7:0] exp_vec(input int el);
        int p;
        logic lr, le, cr, ne;
        p  = el / S;
        if (p > 5) p = 5;
        lr = (p == 1);
        le = (p >= 3);
        cr = (p < 4);
        ne = (p == 5);
        return {3'(p), ne, ne, cr, le, lr};
    endfunction

    // Reference: pin delay line, run-length acceptance, elapsed time since last restart.
    logic       m_s1, m_s2, m_acc;
    int         m_run, m_el;
    int         ecnt = 0;
    logic [7:0] exp_q[$];

    always @(posedge clk) begin
        logic n_s1, n_s2, n_acc;
        int   n_run, n_el;
        if (!reset_n) begin
            m_s1 = 1'b0; m_s2 = 1'b0; m_acc = 1'b1; m_run = 0; m_el = 0;
            ecnt = 0;
            exp_q.push_back(exp_vec(0));
        end else begin
            n_s1  = ext;
            n_s2  = m_s1;
            n_run = m_s2 ? ((m_run < D) ? m_run + 1 : m_run) : 0;
            n_acc = m_s2 && (n_run >= D);
            n_el  = m_acc ? 0 : ((m_el < 6 * S) ? m_el + 1 : m_el);
            m_s1 = n_s1; m_s2 = n_s2; m_run = n_run; m_acc = n_acc; m_el = n_el;
            ecnt++;
            exp_q.push_back(exp_vec(m_el));
        end
    end

    // Transition marks (cycle index) for the directed timing checks.
    int   t_lr_rise, t_lr_fall, t_le_rise, t_cr_fall, t_ne_rise, t_ne_fall;
    logic saw_lrst_off;
    logic [7:0] prev_v = RST_VEC;

    task automatic clear_marks();
        t_lr_rise = -1; t_lr_fall = -1; t_le_rise = -1;
        t_cr_fall = -1; t_ne_rise = -1; t_ne_fall = -1;
        saw_lrst_off = 1'b0;
    endtask

    // Scoreboard pop and invariant checks every cycle, away from the rising edge.
    always @(negedge clk) begin
        logic [7:0] v, e;
        int c;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            v = obs_vec();
            c = ecnt - 1;
            chk("cycle_vec", 32'(v), 32'(e));
            chk("inv_node_en", 32'(v[3] & (v[2] | ~v[1])), 32'd0);
            chk("inv_link", 32'(v[0] & v[1]), 32'd0);
            if (v[0] && !prev_v[0]) t_lr_rise = c;
            if (!v[0] && prev_v[0]) t_lr_fall = c;
            if (v[1] && !prev_v[1]) t_le_rise = c;
            if (!v[2] && prev_v[2]) t_cr_fall = c;
            if (v[3] && !prev_v[3]) t_ne_rise = c;
            if (!v[3] && prev_v[3]) t_ne_fall = c;
            if (v[7:5] == 3'd2) saw_lrst_off = 1'b1;
            prev_v = v;
        end
    end

    task automatic wait_cyc(input int c);
        while (ecnt - 1 < c) @(negedge clk);
    endtask

    task automatic pulse_reset_n();
        @(negedge clk);
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        clear_marks();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int rc, fc;
        reset_n = 1'b0;
        ext     = 1'b0;
        clear_marks();
        repeat (3) @(negedge clk);
        chk("reset_vec", 32'(obs_vec()), 32'(RST_VEC));

        // Plain bring-up with the pin low.
        reset_n = 1'b1;
        clear_marks();
        wait_cyc(45);
        chk("lr_rise", t_lr_rise, 8);
        chk("lr_fall", t_lr_fall, 16);
        chk("le_rise", t_le_rise, 24);
        chk("cr_fall", t_cr_fall, 32);
        chk("ne_rise", t_ne_rise, 40);
        chk("done_vec", 32'(obs_vec()), 32'(DONE_VEC));

        // Short glitch mid-LEN is filtered; timing unchanged.
        pulse_reset_n();
        wait_cyc(25);
        ext = 1'b1;
        repeat (3) @(negedge clk);
        ext = 1'b0;
        wait_cyc(45);
        chk("glitch_cr_fall", t_cr_fall, 32);
        chk("glitch_ne_rise", t_ne_rise, 40);

        // Long pulse in DONE: reset 2 sync + 4 deglitch cycles, then a full replay.
        clear_marks();
        rc  = ecnt;          // cycle index at which the next edge samples the pin
        ext = 1'b1;
        repeat (10) @(negedge clk);
        fc  = ecnt;
        ext = 1'b0;
        wait_cyc(fc + 50);
        chk("ext_ne_fall", t_ne_fall, rc + 6);
        chk("ext_ne_rise", t_ne_rise, fc + 42);
        chk("ext_done_vec", 32'(obs_vec()), 32'(DONE_VEC));

        // Async power-on reset mid CRST_OFF takes effect immediately.
        pulse_reset_n();
        wait_cyc(35);
        chk("pre_async_stage", 32'(bus.stage_o), 32'd4);
        #2 reset_n = 1'b0;
        #1 chk("async_vec", 32'(obs_vec()), 32'(RST_VEC));
        @(negedge clk);
        reset_n = 1'b1;
        clear_marks();

        // Acceptance lands on LRST_ON terminal count: restart wins, LRST_OFF never seen.
        wait_cyc(9);
        ext = 1'b1;
        wait_cyc(15);
        chk("tc_pre_vec", 32'(obs_vec()), 32'(8'b001_0_0_1_0_1));
        wait_cyc(16);
        chk("tc_restart_vec", 32'(obs_vec()), 32'(RST_VEC));
        wait_cyc(20);
        ext = 1'b0;
        chk("tc_no_lrst_off", 32'(saw_lrst_off), 32'd0);

        // Random pin activity; scoreboard and invariants checked each cycle.
        for (int i = 0; i < 10000; i++) begin
            @(negedge clk);
            if (ext) ext = ($urandom_range(99) < 30) ? 1'b0 : 1'b1;
            else     ext = ($urandom_range(99) < 3)  ? 1'b1 : 1'b0;
        end
        ext = 1'b0;
        repeat (60) @(negedge clk);
        chk("final_done_vec", 32'(obs_vec()), 32'(DONE_VEC));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
